// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between two
// valid/ready requesters: IDLE grants, EXEC drives registered operands, RESP holds the result.
module alu_arbiter #(
    parameter int BIT_WIDTH   = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [INSTR_WIDTH-1:0] req0_instr,
    input  logic [BIT_WIDTH-1:0]   req0_a,
    input  logic [BIT_WIDTH-1:0]   req0_b,
    input  logic [INSTR_WIDTH-1:0] req1_instr,
    input  logic [BIT_WIDTH-1:0]   req1_a,
    input  logic [BIT_WIDTH-1:0]   req1_b,
    output logic [1:0]             resp_valid,
    input  logic [1:0]             resp_ready,
    output logic [BIT_WIDTH-1:0]   resp_data,
    output logic [INSTR_WIDTH-1:0] alu_instr,
    output logic [BIT_WIDTH-1:0]   alu_a,
    output logic [BIT_WIDTH-1:0]   alu_b,
    input  logic [BIT_WIDTH-1:0]   alu_c,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t                 state;
    logic                   owner;
    logic                   last_grant;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic [BIT_WIDTH-1:0]   a_q;
    logic [BIT_WIDTH-1:0]   b_q;
    logic [BIT_WIDTH-1:0]   result_q;
    logic [1:0]             grant;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        grant = 2'b00;
        if (state == IDLE) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            instr_q    <= '0;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant[0]) begin
                        instr_q    <= req0_instr;
                        a_q        <= req0_a;
                        b_q        <= req0_b;
                        owner      <= 1'b0;
                        last_grant <= 1'b0;
                        state      <= EXEC;
                    end else if (grant[1]) begin
                        instr_q    <= req1_instr;
                        a_q        <= req1_a;
                        b_q        <= req1_b;
                        owner      <= 1'b1;
                        last_grant <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    result_q <= alu_c;
                    state    <= RESP;
                end
                RESP: begin
                    if (resp_ready[owner]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready  = grant;
    assign resp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign resp_data  = result_q;
    assign alu_instr  = instr_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized bench for alu_arbiter: a transaction-level model predicts
// every visible output each cycle; observed response transfers are compared to constants.
module tb_alu_arbiter;

    localparam int BW = 32;
    localparam int IW = 32;
    localparam logic [31:0] ADD = 32'h0000_0033;
    localparam logic [31:0] SUB = 32'h4000_0033;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    req_valid = 2'b00;
    logic [1:0]    req_ready;
    logic [IW-1:0] req0_instr = '0;
    logic [BW-1:0] req0_a = '0;
    logic [BW-1:0] req0_b = '0;
    logic [IW-1:0] req1_instr = '0;
    logic [BW-1:0] req1_a = '0;
    logic [BW-1:0] req1_b = '0;
    logic [1:0]    resp_valid;
    logic [1:0]    resp_ready = 2'b00;
    logic [BW-1:0] resp_data;
    logic [IW-1:0] alu_instr;
    logic [BW-1:0] alu_a;
    logic [BW-1:0] alu_b;
    logic [BW-1:0] alu_c;
    logic          busy;

    int checks = 0;
    int failures = 0;

    alu_arbiter #(.BIT_WIDTH(BW), .INSTR_WIDTH(IW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_instr(req0_instr), .req0_a(req0_a), .req0_b(req0_b),
        .req1_instr(req1_instr), .req1_a(req1_a), .req1_b(req1_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .alu_instr(alu_instr), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Small stand-in for the core datapath (funct3/funct7 decode).
    function automatic logic [BW-1:0] alu_fn(input logic [IW-1:0] i, input logic [BW-1:0] a, input logic [BW-1:0] b);
        case (i[14:12])
            3'd0:    return (i[31:25] == 7'h20) ? a - b : a + b;
            3'd4:    return a ^ b;
            3'd6:    return a | b;
            3'd7:    return a & b;
            default: return a + b;
        endcase
    endfunction

    always_comb alu_c = alu_fn(alu_instr, alu_a, alu_b);

    // Reference model: one operation in flight, age counts edges since acceptance.
    bit            inflight;
    bit            m_owner;
    bit            m_last;
    int            age;
    logic [BW-1:0] m_result;
    logic [BW-1:0] m_rd;
    logic [IW-1:0] m_instr;
    logic [BW-1:0] m_a;
    logic [BW-1:0] m_b;
    bit            drop_on_accept = 1'b0;
    logic [32:0]   obs_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        inflight = 1'b0;
        m_owner  = 1'b0;
        m_last   = 1'b1;
        age      = 0;
        m_result = '0;
        m_rd     = '0;
        m_instr  = '0;
        m_a      = '0;
        m_b      = '0;
    endtask

    task automatic cycle();
        logic [1:0] g;
        logic [1:0] rv;
        #1;
        g = 2'b00;
        if (!inflight) begin
            if (req_valid == 2'b01 || (req_valid == 2'b11 && m_last)) g = 2'b01;
            else if (req_valid == 2'b10 || req_valid == 2'b11) g = 2'b10;
        end
        rv = (inflight && age >= 1) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
        chk("req_ready", 32'(req_ready), 32'(g));
        chk("busy", 32'(busy), 32'(inflight));
        chk("resp_valid", 32'(resp_valid), 32'(rv));
        chk("resp_data", resp_data, m_rd);
        chk("alu_instr", alu_instr, m_instr);
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        if (!rst) begin
            for (int i = 0; i < 2; i++)
                if (resp_valid[i] && resp_ready[i]) obs_q.push_back({i[0], resp_data});
        end
        if (rst) begin
            model_reset();
        end else if (!inflight) begin
            if (g != 2'b00) begin
                inflight = 1'b1;
                age      = 0;
                m_owner  = g[1];
                m_last   = g[1];
                m_instr  = g[1] ? req1_instr : req0_instr;
                m_a      = g[1] ? req1_a : req0_a;
                m_b      = g[1] ? req1_b : req0_b;
                m_result = alu_fn(m_instr, m_a, m_b);
            end
        end else if (age == 0) begin
            age  = 1;
            m_rd = m_result;
        end else if (resp_ready[m_owner]) begin
            inflight = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        if (drop_on_accept) req_valid = req_valid & ~g;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic check_obs(input string tag, input int n, input logic [32:0] exp[4]);
        chk({tag, "_count"}, 32'(obs_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            logic [32:0] o;
            o = (i < obs_q.size()) ? obs_q[i] : 'x;
            chk({tag, "_owner"}, 32'(o[32]), 32'(exp[i][32]));
            chk({tag, "_data"}, o[31:0], exp[i][31:0]);
        end
        obs_q.delete();
    endtask

    initial begin
        logic [32:0] e[4];
        logic [31:0] itab[5];
        itab = '{ADD, SUB, 32'h0000_7033, 32'h0000_6033, 32'h0000_4033};

        @(posedge clk);
        @(negedge clk);
        model_reset();
        cycle();
        rst = 1'b0;

        // 1: single ADD 5+3 from requester 0
        drop_on_accept = 1'b1;
        req0_instr = ADD; req0_a = 32'd5; req0_b = 32'd3;
        resp_ready = 2'b01; req_valid = 2'b01;
        repeat (5) cycle();
        e = '{{1'b0, 32'd8}, '0, '0, '0};
        check_obs("t1", 1, e);

        // 2: both continuously valid, strict alternation from requester 0
        do_reset();
        drop_on_accept = 1'b0;
        req0_instr = ADD; req0_a = 32'd10; req0_b = 32'd1;
        req1_instr = SUB; req1_a = 32'd10; req1_b = 32'd1;
        resp_ready = 2'b11; req_valid = 2'b11;
        repeat (12) cycle();
        e = '{{1'b0, 32'd11}, {1'b1, 32'd9}, {1'b0, 32'd11}, {1'b1, 32'd9}};
        check_obs("t2", 4, e);

        // 3: backpressure with both requesters pending
        do_reset();
        resp_ready = 2'b00;
        repeat (8) cycle();
        resp_ready = 2'b11;
        cycle();
        req_valid = 2'b00;
        repeat (3) cycle();
        e = '{{1'b0, 32'd11}, '0, '0, '0};
        check_obs("t3", 1, e);

        // 4: owner 1 ignores resp_ready on bit 0
        do_reset();
        drop_on_accept = 1'b1;
        req1_instr = ADD; req1_a = 32'd7; req1_b = 32'd9;
        resp_ready = 2'b01; req_valid = 2'b10;
        repeat (6) cycle();
        resp_ready = 2'b10;
        repeat (2) cycle();
        e = '{{1'b1, 32'd16}, '0, '0, '0};
        check_obs("t4", 1, e);

        // 5: reset in EXEC and in RESP discards the operation
        do_reset();
        drop_on_accept = 1'b0;
        resp_ready = 2'b00; req_valid = 2'b11;
        cycle();
        do_reset();
        #1;
        chk("t5_exec_ready", 32'(req_ready), 32'h1);
        chk("t5_exec_busy", 32'(busy), 32'h0);
        cycle();
        cycle();
        do_reset();
        #1;
        chk("t5_resp_valid", 32'(resp_valid), 32'h0);
        chk("t5_resp_ready", 32'(req_ready), 32'h1);
        chk("t5_no_resp", 32'(obs_q.size()), 32'h0);
        req_valid = 2'b00;
        cycle();

        // 6: operands change right after acceptance
        do_reset();
        drop_on_accept = 1'b1;
        req0_instr = ADD; req0_a = 32'hFFFF_FFFF; req0_b = 32'd1;
        resp_ready = 2'b01; req_valid = 2'b01;
        cycle();
        req0_a = 32'h1234_5678; req0_b = 32'h0000_0100;
        repeat (3) cycle();
        e = '{{1'b0, 32'h0}, '0, '0, '0};
        check_obs("t6", 1, e);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            drop_on_accept = 1'b0;
            rst        = ($urandom_range(0, 60) == 0);
            req_valid  = 2'($urandom_range(0, 3));
            resp_ready = 2'($urandom_range(0, 3));
            req0_instr = itab[$urandom_range(0, 4)];
            req1_instr = itab[$urandom_range(0, 4)];
            req0_a = $urandom; req0_b = $urandom;
            req1_a = $urandom; req1_b = $urandom;
            cycle();
        end
        rst = 1'b0;
        req_valid = 2'b00;
        resp_ready = 2'b11;
        repeat (4) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
